// File: rtl/blink_pwm_multi.sv
// -----------------------------------------------------------------------------
// blink_pwm_multi
//
// N-channel blink/PWM generator. Each channel counts 0..period-1 and drives
// its LED high while the count is below the duty value. Period and duty are
// written through a shadow register per channel. A new setting takes effect
// only when the channel wraps, so the output never glitches mid-period.
//
// Ports
//   clk         system clock; all state changes on posedge
//   rst_n       synchronous active-low reset
//   en          global count enable; low freezes every counter and LED
//   sync_all    one-cycle pulse: zero every counter on the same edge and
//               apply any pending shadow settings
//   cfg_we      configuration write request
//   cfg_ch      target channel of the write
//   cfg_period  new period in cycles (0 disables the channel)
//   cfg_duty    new duty in cycles high
//   cfg_ready   shadow slot of cfg_ch is free (0 for channels >= N_CH)
//   led         per-channel PWM output
//   wrap        per-channel end-of-period strobe
// -----------------------------------------------------------------------------
module blink_pwm_multi #(
    parameter int N_CH       = 3,
    parameter int CW         = 26,
    parameter int CHW        = 2,
    parameter int DEF_PERIOD = 50,
    parameter int DEF_DUTY   = 25
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            sync_all,
    input  logic            cfg_we,
    input  logic [CHW-1:0]  cfg_ch,
    input  logic [CW-1:0]   cfg_period,
    input  logic [CW-1:0]   cfg_duty,
    output logic            cfg_ready,
    output logic [N_CH-1:0] led,
    output logic [N_CH-1:0] wrap
);

    localparam logic [CW-1:0] DEF_P = CW'(DEF_PERIOD);
    localparam logic [CW-1:0] DEF_D = CW'(DEF_DUTY);

    // Pending flags gathered from the channel slices for the ready lookup.
    logic [N_CH-1:0] pending_vec;

    // Only indices that name a real channel can report a free slot.
    always_comb begin
        cfg_ready = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_ch == CHW'(i)) begin
                cfg_ready = ~pending_vec[i];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CW-1:0] cnt_q, cnt_d;
            logic [CW-1:0] act_period_q, act_period_d;
            logic [CW-1:0] act_duty_q, act_duty_d;
            logic [CW-1:0] shd_period_q, shd_period_d;
            logic [CW-1:0] shd_duty_q, shd_duty_d;
            logic          pending_q, pending_d;
            logic          active;
            logic          at_end;
            logic          wrap_int;
            logic          apply;
            logic          accept;

            assign active   = (act_period_q != '0);
            // Counter never exceeds period-1, so an all-ones period is safe.
            assign at_end   = (cnt_q == act_period_q - CW'(1));
            assign wrap_int = en & active & at_end;
            // A disabled channel has no wrap, so it picks up a pending
            // setting on the very next edge.
            assign apply    = pending_q & (sync_all | wrap_int | ~active);
            assign accept   = cfg_we & cfg_ready & (cfg_ch == CHW'(gi));

            always_comb begin
                cnt_d        = cnt_q;
                act_period_d = act_period_q;
                act_duty_d   = act_duty_q;
                shd_period_d = shd_period_q;
                shd_duty_d   = shd_duty_q;
                pending_d    = pending_q;

                if (sync_all) begin
                    cnt_d = '0;
                end else if (en && active) begin
                    cnt_d = at_end ? '0 : cnt_q + CW'(1);
                end

                if (apply) begin
                    act_period_d = shd_period_q;
                    act_duty_d   = shd_duty_q;
                    pending_d    = 1'b0;
                end

                // Acceptance needs a free slot, so it cannot collide with an
                // apply of older data; evaluated last so a new write wins.
                if (accept) begin
                    shd_period_d = cfg_period;
                    shd_duty_d   = cfg_duty;
                    pending_d    = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q        <= '0;
                    act_period_q <= DEF_P;
                    act_duty_q   <= DEF_D;
                    shd_period_q <= '0;
                    shd_duty_q   <= '0;
                    pending_q    <= 1'b0;
                end else begin
                    cnt_q        <= cnt_d;
                    act_period_q <= act_period_d;
                    act_duty_q   <= act_duty_d;
                    shd_period_q <= shd_period_d;
                    shd_duty_q   <= shd_duty_d;
                    pending_q    <= pending_d;
                end
            end

            assign pending_vec[gi] = pending_q;
            assign led[gi]         = active & (cnt_q < act_duty_q);
            // The sync edge restarts the period; it is not a natural wrap.
            assign wrap[gi]        = wrap_int & ~sync_all;
        end
    endgenerate

endmodule

// File: tb/tb_blink_pwm_multi.sv
// -----------------------------------------------------------------------------
// tb_blink_pwm_multi
//
// Directed bench for blink_pwm_multi with N_CH=3, CW=8, DEF_PERIOD=10,
// DEF_DUTY=4. Inputs change 1 time unit after the rising edge; outputs are
// sampled 1-2 units later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_blink_pwm_multi;
    localparam int N_CH = 3;
    localparam int CW   = 8;
    localparam int CHW  = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            sync_all;
    logic            cfg_we;
    logic [CHW-1:0]  cfg_ch;
    logic [CW-1:0]   cfg_period;
    logic [CW-1:0]   cfg_duty;
    logic            cfg_ready;
    logic [N_CH-1:0] led;
    logic [N_CH-1:0] wrap;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    blink_pwm_multi #(
        .N_CH(N_CH), .CW(CW), .CHW(CHW), .DEF_PERIOD(10), .DEF_DUTY(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_all(sync_all),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
        .cfg_duty(cfg_duty), .cfg_ready(cfg_ready), .led(led), .wrap(wrap)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_set(input int ch, input int p, input int d);
        cfg_we     = 1'b1;
        cfg_ch     = CHW'(ch);
        cfg_period = CW'(p);
        cfg_duty   = CW'(d);
    endtask

    // Default 10/4 waveform on every channel, k edges after alignment.
    function automatic void exp_def(input int k, output logic [2:0] l, output logic [2:0] w);
        int c;
        c = k % 10;
        l = (c < 4) ? 3'b111 : 3'b000;
        w = (c == 9) ? 3'b111 : 3'b000;
    endfunction

    // Main run, t counted from the edge where ch1 switched to 6/3.
    // ch0: 10/4, then 10/0 from t=20, disabled t=50..53, 4/2 from t=54.
    // ch1: 6/3 throughout. ch2: 10/4, then 10/12 from t=30.
    function automatic void exp_main(input int t, output logic [2:0] l, output logic [2:0] w);
        int c;
        if (t < 50) begin
            c = t % 10;
            l[0] = (t < 20) ? (c < 4) : 1'b0;
            w[0] = (c == 9);
        end else if (t < 54) begin
            l[0] = 1'b0;
            w[0] = 1'b0;
        end else begin
            c = (t - 54) % 4;
            l[0] = (c < 2);
            w[0] = (c == 3);
        end
        c = t % 6;
        l[1] = (c < 3);
        w[1] = (c == 5);
        c = t % 10;
        l[2] = (t < 30) ? (c < 4) : 1'b1;
        w[2] = (c == 9);
    endfunction

    // After sync_all: ch0 4/2, ch1 6/3, ch2 5/2 (applied by the sync).
    function automatic void exp_sync(input int s, output logic [2:0] l, output logic [2:0] w);
        l[0] = ((s % 4) < 2);  w[0] = ((s % 4) == 3);
        l[1] = ((s % 6) < 3);  w[1] = ((s % 6) == 5);
        l[2] = ((s % 5) < 2);  w[2] = ((s % 5) == 4);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] el, ew;

        // Reset
        rst_n = 1'b0; en = 1'b0; sync_all = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_period = '0; cfg_duty = '0;
        tick; tick;
        check("rst led", 32'(led), 32'h7);
        check("rst wrap", 32'(wrap), 32'h0);
        check("rst ready", 32'(cfg_ready), 32'h1);

        // Default waveform
        rst_n = 1'b1; en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            exp_def(k, el, ew);
            check($sformatf("def led k=%0d", k), 32'(led), 32'(el));
            check($sformatf("def wrap k=%0d", k), 32'(wrap), 32'(ew));
            tick;
        end

        // Shadow update and busy drop on ch1 (k=20 here)
        tick; tick; tick;
        cfg_ch = 2'd1; #1;
        check("ready before write", 32'(cfg_ready), 32'h1);
        cfg_set(1, 6, 3);
        tick;
        cfg_we = 1'b0; #1;
        check("ready while pending", 32'(cfg_ready), 32'h0);
        cfg_set(1, 20, 10); #1;
        check("ready busy write", 32'(cfg_ready), 32'h0);
        tick;
        cfg_we = 1'b0;
        cfg_ch = 2'd0; #1;
        check("ready ch0 free", 32'(cfg_ready), 32'h1);
        cfg_ch = 2'd2; #1;
        check("ready ch2 free", 32'(cfg_ready), 32'h1);
        cfg_ch = 2'd3; #1;
        check("ready bad ch", 32'(cfg_ready), 32'h0);
        cfg_ch = 2'd1;
        tick; tick; tick; tick;
        check("old period led k=29", 32'(led), 32'h0);
        check("old period wrap k=29", 32'(wrap), 32'h7);
        check("ready before apply", 32'(cfg_ready), 32'h0);
        tick;
        check("ready after apply", 32'(cfg_ready), 32'h1);

        // Edge duties, disable, apply on disabled channel
        for (int t = 0; t < 76; t++) begin
            cfg_we = 1'b0;
            case (t)
                18: cfg_set(0, 10, 0);
                19: cfg_set(2, 10, 12);
                40: cfg_set(0, 0, 5);
                52: cfg_set(0, 4, 2);
                default: ;
            endcase
            if (t == 70) begin
                // Freeze for 7 edges; the LEDs hold, no wrap is shown.
                for (int i = 0; i < 7; i++) begin
                    en = 1'b0; #1;
                    check($sformatf("frozen led i=%0d", i), 32'(led), 32'h5);
                    check($sformatf("frozen wrap i=%0d", i), 32'(wrap), 32'h0);
                    tick;
                end
                en = 1'b1;
            end
            #1;
            exp_main(t, el, ew);
            check($sformatf("main led t=%0d", t), 32'(led), 32'(el));
            check($sformatf("main wrap t=%0d", t), 32'(wrap), 32'(ew));
            if (t == 53) check("ready disabled pending", 32'(cfg_ready), 32'h0);
            if (t == 54) check("ready disabled applied", 32'(cfg_ready), 32'h1);
            tick;
        end

        // Skewed at t=76: queue ch2 5/2, then sync while ch0/ch1 sit at wrap.
        cfg_set(2, 5, 2); #1;
        exp_main(76, el, ew);
        check("pre-sync led t=76", 32'(led), 32'(el));
        tick;
        cfg_we = 1'b0;
        sync_all = 1'b1; #1;
        check("sync wrap masked", 32'(wrap), 32'h0);
        tick;
        sync_all = 1'b0;
        for (int s = 0; s < 12; s++) begin
            #1;
            exp_sync(s, el, ew);
            check($sformatf("sync led s=%0d", s), 32'(led), 32'(el));
            check($sformatf("sync wrap s=%0d", s), 32'(wrap), 32'(ew));
            tick;
        end

        // Reset mid-operation with a pending write and competing events
        cfg_set(1, 8, 1);
        tick;
        cfg_we = 1'b0;
        rst_n = 1'b0; sync_all = 1'b1;
        cfg_set(2, 3, 3);
        tick;
        sync_all = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd1; #1;
        check("mid rst led", 32'(led), 32'h7);
        check("mid rst wrap", 32'(wrap), 32'h0);
        check("mid rst ready ch1", 32'(cfg_ready), 32'h1);
        cfg_ch = 2'd2; #1;
        check("mid rst ready ch2", 32'(cfg_ready), 32'h1);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            #1;
            exp_def(k, el, ew);
            check($sformatf("post rst led k=%0d", k), 32'(led), 32'(el));
            check($sformatf("post rst wrap k=%0d", k), 32'(wrap), 32'(ew));
            tick;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
